microsequencer: RTL and testbench

//  Micro-program sequencer for the multicycle RV32I core. Owns the micro-PC, drives the

---
 rtl/microcode_pkg.sv | 51 +++++
 rtl/upc_dispatch.sv | 54 +++++
 rtl/microsequencer.sv | 111 +++++++++++
 tb/tb_microsequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/microcode_pkg.sv
// Shared definitions for the RV32I microcode sequencer: control-word layout,
// sequencing codes, opcodes and micro-addresses.
package microcode_pkg;

  localparam int unsigned UPC_WIDTH  = 4;
  localparam int unsigned WORD_WIDTH = 17;
  localparam int unsigned N_STATES   = 11;
  localparam int unsigned CNT_WIDTH  = 32;

  typedef struct packed {
    logic       branch;
    logic       pcupd;
    logic       regw;
    logic       memw;
    logic       irw;
    logic       adrsrc;
    logic [1:0] res;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] alu_op;
    logic [2:0] seq;
  } uword_t;

  typedef enum logic [2:0] {
    SEQ_NEXT  = 3'b000,
    SEQ_DISP1 = 3'b001,
    SEQ_DISP2 = 3'b010,
    SEQ_FETCH = 3'b011,
    SEQ_ALUWB = 3'b100
  } seq_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_EXECI    = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_BEQ      = 4'd10;

endpackage

// File: rtl/upc_dispatch.sv
// Next micro-address selection: decodes the sequencing field and the opcode
// dispatch tables, flagging reserved codes, unknown opcodes and unpopulated states.
module upc_dispatch
  import microcode_pkg::*;
(
  input  logic [2:0]           seq,
  input  logic [6:0]           opcode,
  input  logic [UPC_WIDTH-1:0] upc,
  output logic [UPC_WIDTH-1:0] next_upc,
  output logic                 illegal
);

  logic bad_code;

  // Next-address mux over the sequencing field and both dispatch tables
  always_comb begin
    next_upc = upc + 4'd1;
    bad_code = 1'b0;
    case (seq)
      SEQ_NEXT:  next_upc = upc + 4'd1;
      SEQ_DISP1: begin
        case (opcode)
          OP_LW, OP_SW: next_upc = S_MEMADR;
          OP_R:         next_upc = S_EXECR;
          OP_I:         next_upc = S_EXECI;
          OP_JAL:       next_upc = S_JAL;
          OP_BEQ:       next_upc = S_BEQ;
          default: begin
            next_upc = S_FETCH;
            bad_code = 1'b1;
          end
        endcase
      end
      SEQ_DISP2: begin
        case (opcode)
          OP_LW: next_upc = S_MEMREAD;
          OP_SW: next_upc = S_MEMWRITE;
          default: begin
            next_upc = S_FETCH;
            bad_code = 1'b1;
          end
        endcase
      end
      SEQ_FETCH: next_upc = S_FETCH;
      SEQ_ALUWB: next_upc = S_ALUWB;
      default: begin
        next_upc = S_FETCH;
        bad_code = 1'b1;
      end
    endcase
    illegal = bad_code | (32'(upc) >= N_STATES);
  end

endmodule

// File: rtl/microsequencer.sv
// Micro-program sequencer: owns the micro-PC, stalls on memory handshakes,
// gates architectural write enables and halts on illegal micro-flow.
module microsequencer
  import microcode_pkg::*;
#(
  parameter int UPC_W      = UPC_WIDTH,
  parameter int WORD_W     = WORD_WIDTH,
  parameter int NUM_STATES = N_STATES,
  parameter int CNT_W      = CNT_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        opcode,
  input  logic              zero,
  input  logic              mem_ready,
  output logic [UPC_W-1:0]  upc,
  input  logic [WORD_W-1:0] uword,
  output logic              pc_write,
  output logic              reg_write,
  output logic              mem_write,
  output logic              ir_write,
  output logic              adr_src,
  output logic [1:0]        result_src,
  output logic [1:0]        alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [1:0]        alu_op,
  output logic              mem_req,
  output logic              illegal_op,
  output logic [CNT_W-1:0]  instr_count
);

  uword_t            w;
  logic [UPC_W-1:0]  upc_q, upc_d, next_upc;
  logic              halted_q, halted_d;
  logic              illegal_q, illegal_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              disp_illegal;
  logic              mem_req_raw;
  logic              stall;
  logic              pass;

  assign w = uword;

  upc_dispatch u_dispatch (
    .seq      (w.seq),
    .opcode   (opcode),
    .upc      (upc_q),
    .next_upc (next_upc),
    .illegal  (disp_illegal)
  );

  // Output decode; enables are suppressed while waiting on memory or halted
  always_comb begin
    mem_req_raw = w.irw | w.adrsrc;
    stall       = mem_req_raw & ~mem_ready;
    pass        = ~(stall | halted_q);
    pc_write    = (w.pcupd | (w.branch & zero)) & pass;
    reg_write   = w.regw & pass;
    mem_write   = w.memw & pass;
    ir_write    = w.irw & pass;
    mem_req     = mem_req_raw & ~halted_q;
    adr_src     = w.adrsrc;
    result_src  = w.res;
    alu_src_a   = w.src_a;
    alu_src_b   = w.src_b;
    alu_op      = w.alu_op;
    upc         = upc_q;
    illegal_op  = illegal_q;
    instr_count = cnt_q;
  end

  // Next-state: halt dominates, then illegal detection, then stall hold
  always_comb begin
    upc_d     = upc_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    if (halted_q) begin
      upc_d = S_FETCH;
    end else if (disp_illegal) begin
      upc_d     = S_FETCH;
      halted_d  = 1'b1;
      illegal_d = 1'b1;
    end else if (stall) begin
      upc_d = upc_q;
    end else begin
      upc_d = next_upc;
      if (w.seq == SEQ_FETCH) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      upc_q     <= S_FETCH;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      upc_q     <= upc_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_microsequencer.sv
// Directed bench for microsequencer: a local control store feeds uword back
// and every step compares outputs against hand-computed values.
module tb_microsequencer;

  logic        clk = 1'b0;
  logic        reset, zero, mem_ready;
  logic [6:0]  opcode;
  logic [3:0]  upc;
  logic [16:0] uword;
  logic        pc_write, reg_write, mem_write, ir_write, adr_src, mem_req, illegal_op;
  logic [1:0]  result_src, alu_src_a, alu_src_b, alu_op;
  logic [31:0] instr_count;
  logic [16:0] rom [16];
  logic        ovr_en;
  logic [16:0] ovr_word;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign uword = ovr_en ? ovr_word : rom[upc];

  microsequencer dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .upc(upc), .uword(uword), .pc_write(pc_write), .reg_write(reg_write),
    .mem_write(mem_write), .ir_write(ir_write), .adr_src(adr_src),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .mem_req(mem_req), .illegal_op(illegal_op),
    .instr_count(instr_count)
  );

  function automatic logic [16:0] mk(input logic br, input logic pcu, input logic rw,
                                     input logic mw, input logic iw, input logic as,
                                     input logic [1:0] res, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [1:0] aop,
                                     input logic [2:0] sq);
    return {br, pcu, rw, mw, iw, as, res, sa, sb, aop, sq};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic exp_en(input string tag, input logic [3:0] u, input logic pcw,
                        input logic rw, input logic mw, input logic iw);
    #1;
    chk({tag, "_upc"}, 32'(upc), 32'(u));
    chk({tag, "_en"}, {28'd0, pc_write, reg_write, mem_write, ir_write},
        {28'd0, pcw, rw, mw, iw});
  endtask

  task automatic exp_fields(input string tag, input logic [1:0] res, input logic [1:0] sa,
                            input logic [1:0] sb, input logic [1:0] aop);
    chk({tag, "_fld"}, {24'd0, result_src, alu_src_a, alu_src_b, alu_op},
        {24'd0, res, sa, sb, aop});
  endtask

  initial begin
    rom[0]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
    rom[1]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b001);
    rom[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b010);
    rom[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    rom[4]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b011);
    rom[5]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b011);
    rom[6]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b100);
    rom[7]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b011);
    rom[8]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10, 3'b100);
    rom[9]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 3'b100);
    rom[10] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 3'b011);
    for (int i = 11; i < 16; i++) rom[i] = 17'h00007;

    ovr_en = 1'b0; ovr_word = 17'h00000;
    reset = 1'b1; zero = 1'b0; mem_ready = 1'b1; opcode = 7'b0000011;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_upc", 32'(upc), 32'd0);
    chk("rst_illegal", 32'(illegal_op), 32'd0);
    chk("rst_count", instr_count, 32'd0);

    // lw with memory always ready
    exp_en("lw0", 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(); exp_en("lw1", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); exp_en("lw2", 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); exp_en("lw3", 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lw3_memreq", 32'(mem_req), 32'd1);
    tick(); exp_en("lw4", 4'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); exp_en("lw_end", 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("lw_count", instr_count, 32'd1);

    // sw with three wait cycles in MemWrite
    opcode = 7'b0100011;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_en("sw_wait", 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    mem_ready = 1'b1;
    exp_en("sw_ready", 4'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(); exp_en("sw_end", 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("sw_count", instr_count, 32'd2);

    // beq taken then not taken
    opcode = 7'b1100011; zero = 1'b1;
    tick(); tick(); exp_en("beq_t", 4'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); exp_en("beq_t_end", 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    zero = 1'b0;
    tick(); tick(); exp_en("beq_n", 4'd10, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); exp_en("beq_n_end", 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("beq_count", instr_count, 32'd4);

    // jal and addi through ALUWB, checking the mux fields per state
    opcode = 7'b1101111;
    exp_fields("jal0", 2'b10, 2'b00, 2'b10, 2'b00);
    tick(); exp_fields("jal1", 2'b00, 2'b01, 2'b01, 2'b00);
    tick(); exp_en("jal9", 4'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_fields("jal9", 2'b00, 2'b01, 2'b10, 2'b00);
    tick(); exp_en("jal7", 4'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_fields("jal7", 2'b00, 2'b00, 2'b00, 2'b00);
    tick(); exp_en("jal_end", 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    opcode = 7'b0010011;
    tick(); tick(); exp_en("addi8", 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_fields("addi8", 2'b00, 2'b10, 2'b01, 2'b10);
    tick(); exp_en("addi7", 4'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); exp_en("addi_end", 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("addi_count", instr_count, 32'd6);

    // reset while stalled in MemRead abandons the load
    opcode = 7'b0000011;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    exp_en("st_mr", 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); exp_en("st_hold", 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_en("st_rst", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("st_rst_count", instr_count, 32'd0);
    mem_ready = 1'b1;
    #1;
    chk("st_fetch_iw", 32'(ir_write), 32'd1);

    // unsupported opcode in Decode halts the sequencer
    opcode = 7'b1110011;
    tick(); exp_en("ill_dec", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ill_pre", 32'(illegal_op), 32'd0);
    tick();
    #1;
    chk("ill_set", 32'(illegal_op), 32'd1);
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      opcode = 7'b0000011;
      #1;
      chk("halt_upc", 32'(upc), 32'd0);
      chk("halt_en", {27'd0, pc_write, reg_write, mem_write, ir_write, mem_req}, 32'd0);
      tick();
    end
    chk("halt_sticky", 32'(illegal_op), 32'd1);
    chk("halt_count", instr_count, 32'd0);
    reset = 1'b1; mem_ready = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("clr_illegal", 32'(illegal_op), 32'd0);
    exp_en("clr_fetch", 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);

    // reserved sequencing code
    ovr_en = 1'b1; ovr_word = 17'h00005;
    tick();
    #1;
    chk("rsv_illegal", 32'(illegal_op), 32'd1);
    chk("rsv_upc", 32'(upc), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // walk past the last populated state
    ovr_word = 17'h00000;
    for (int i = 1; i < 12; i++) begin
      tick();
      #1;
      chk("walk_upc", 32'(upc), 32'(i));
    end
    chk("walk_pre", 32'(illegal_op), 32'd0);
    tick();
    #1;
    chk("walk_illegal", 32'(illegal_op), 32'd1);
    chk("walk_upc0", 32'(upc), 32'd0);
    ovr_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
